// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch front end with in-order response queue
module if_fetch_unit #(
    parameter int unsigned DEPTH    = 2,             // in-flight + queued capacity, power of two 2..8
    parameter logic [31:0] RESET_PC = 32'h0000_0000  // word aligned
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        ex_b_flag,
    input  logic [31:0] ex_b_addr,
    input  logic        id_b_flag,
    input  logic [31:0] id_b_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam logic [CW:0] CAP = DEPTH[CW:0];

    // Architectural fetch state
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] count_q, count_d;

    // In-flight PC tracker: one entry per granted, not yet answered request
    logic [PW-1:0] trk_wr_q, trk_wr_d;
    logic [PW-1:0] trk_rd_q, trk_rd_d;
    logic [31:0]   trk_pc_q [DEPTH];

    // Output queue of {pc, inst} pairs
    logic [PW-1:0] q_wr_q, q_wr_d;
    logic [PW-1:0] q_rd_q, q_rd_d;
    logic [31:0]   q_pc_q   [DEPTH];
    logic [31:0]   q_inst_q [DEPTH];

    logic          redirect;
    logic [31:0]   redirect_pc;
    logic [CW:0]   occupancy;
    logic          has_room;
    logic          grant;
    logic          resp;
    logic          resp_keep;
    logic          pop;

    // Low address bits of redirect targets and the upper stall bits are not used by fetch
    logic          unused_bits;
    assign unused_bits = ^{stall[5:2], ex_b_addr[1:0], id_b_addr[1:0]};

    assign redirect    = ex_b_flag | id_b_flag;
    assign redirect_pc = ex_b_flag ? {ex_b_addr[31:2], 2'b00} : {id_b_addr[31:2], 2'b00};

    // Every in-flight request reserves a queue slot, so the queue can never overflow
    assign occupancy = {1'b0, outstanding_q} + {1'b0, count_q};
    assign has_room  = occupancy < CAP;

    assign imem_req  = !rst && !stall[0] && !redirect && has_room;
    assign imem_addr = fetch_pc_q;
    assign grant     = imem_req && imem_gnt;

    // A response with nothing outstanding (e.g. left over from before a reset) is ignored
    assign resp      = imem_rvalid && (outstanding_q != '0);
    assign resp_keep = resp && (drop_cnt_q == '0) && !redirect;
    assign pop       = (count_q != '0) && !stall[1] && !redirect;

    // Next fetch PC: redirect wins, otherwise advance on grant (wraps naturally at 2^32)
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
        end else if (grant) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    // In-flight bookkeeping: tracker pointers and outstanding count
    always_comb begin
        outstanding_d = outstanding_q;
        trk_wr_d      = trk_wr_q;
        trk_rd_d      = trk_rd_q;
        if (grant) begin
            trk_wr_d = trk_wr_q + 1'b1;
        end
        if (resp) begin
            trk_rd_d = trk_rd_q + 1'b1;
        end
        case ({grant, resp})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Stale-response counter. On a redirect every request still in flight after this
    // cycle is stale; that set already contains any drops pending from earlier redirects,
    // so back-to-back redirects accumulate without counting the same request twice.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (redirect) begin
            drop_cnt_d = outstanding_q - {{(CW-1){1'b0}}, resp};
        end else if (resp && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - 1'b1;
        end
    end

    // Output queue pointers and occupancy; a redirect empties it outright
    always_comb begin
        count_d = count_q;
        q_wr_d  = q_wr_q;
        q_rd_d  = q_rd_q;
        if (redirect) begin
            count_d = '0;
            q_wr_d  = '0;
            q_rd_d  = '0;
        end else begin
            if (resp_keep) begin
                q_wr_d = q_wr_q + 1'b1;
            end
            if (pop) begin
                q_rd_d = q_rd_q + 1'b1;
            end
            case ({resp_keep, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            trk_wr_q      <= '0;
            trk_rd_q      <= '0;
            q_wr_q        <= '0;
            q_rd_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            trk_wr_q      <= trk_wr_d;
            trk_rd_q      <= trk_rd_d;
            q_wr_q        <= q_wr_d;
            q_rd_q        <= q_rd_d;
        end
    end

    // Entry storage; contents are only meaningful behind the reset pointers
    always_ff @(posedge clk) begin
        if (grant) begin
            trk_pc_q[trk_wr_q] <= fetch_pc_q;
        end
        if (resp_keep) begin
            q_pc_q[q_wr_q]   <= trk_pc_q[trk_rd_q];
            q_inst_q[q_wr_q] <= imem_rdata;
        end
    end

    // Present the queue head, or a zero bubble when empty or in reset
    always_comb begin
        if_pc   = 32'h0;
        if_inst = 32'h0;
        if (!rst && (count_q != '0)) begin
            if_pc   = q_pc_q[q_rd_q];
            if_inst = q_inst_q[q_rd_q];
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        ex_b_flag;
    logic [31:0] ex_b_addr;
    logic        id_b_flag;
    logic [31:0] id_b_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    always #5 clk = ~clk;

    if_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .ex_b_flag  (ex_b_flag),
        .ex_b_addr  (ex_b_addr),
        .id_b_flag  (id_b_flag),
        .id_b_addr  (id_b_addr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .if_pc      (if_pc),
        .if_inst    (if_inst)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int notes  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    endtask

    // Instruction memory: remembers granted addresses, answers in order when allowed
    logic [31:0] mem_q[$];
    logic        rsp_en;

    always @(negedge clk) begin
        if (imem_req && imem_gnt) mem_q.push_back(imem_addr);
    end

    // Reference model: fetch PC, in-flight list with stale marks, output queue
    logic [31:0] m_pc = RESET_PC;
    logic [32:0] m_infl[$];
    logic [63:0] m_outq[$];

    always @(negedge clk) begin : compare_proc
        logic        e_req;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        redir;
        logic        do_pop;
        logic [32:0] ent;
        redir = ex_b_flag | id_b_flag;
        e_req = !rst && !stall[0] && !redir && ((m_infl.size() + m_outq.size()) < DEPTH);
        e_pc   = 32'h0;
        e_inst = 32'h0;
        if (!rst && m_outq.size() > 0) {e_pc, e_inst} = m_outq[0];
        chk1("model_req", imem_req, e_req);
        if (e_req) chk("model_addr", imem_addr, m_pc);
        chk("model_if_pc", if_pc, e_pc);
        chk("model_if_inst", if_inst, e_inst);
        if (rst) begin
            m_pc = RESET_PC;
            m_infl.delete();
            m_outq.delete();
        end else begin
            do_pop = !redir && !stall[1] && (m_outq.size() > 0);
            if (imem_rvalid) begin
                if (m_infl.size() == 0) begin
                    notes++;
                    $display("note: rvalid with nothing outstanding (protocol error), ignored, t=%0t", $time);
                end else begin
                    ent = m_infl.pop_front();
                    if (!ent[32] && !redir) m_outq.push_back({ent[31:0], imem_rdata});
                end
            end
            if (do_pop) void'(m_outq.pop_front());
            if (redir) begin
                m_outq.delete();
                for (int k = 0; k < m_infl.size(); k++) begin
                    ent = m_infl[k];
                    ent[32] = 1'b1;
                    m_infl[k] = ent;
                end
                m_pc = ex_b_flag ? (ex_b_addr & ~32'h3) : (id_b_addr & ~32'h3);
            end else if (e_req && imem_gnt) begin
                m_infl.push_back({1'b0, m_pc});
                m_pc = m_pc + 32'd4;
            end
        end
    end

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
        if (rsp_en && mem_q.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_q.pop_front() ^ KEY;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            to_neg();
            to_pos();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 6'b0; ex_b_flag = 1'b0; id_b_flag = 1'b0;
        imem_gnt = 1'b0; rsp_en = 1'b0; imem_rvalid = 1'b0;
        mem_q.delete();
        cyc(2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    logic [15:0] pg, pr, ps1, ps0;
    logic        got;

    initial begin
        rst = 1'b1; stall = 6'b0; ex_b_flag = 1'b0; ex_b_addr = 32'h0;
        id_b_flag = 1'b0; id_b_addr = 32'h0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0; rsp_en = 1'b0;
        cyc(3);
        to_neg();
        chk1("rst_req", imem_req, 1'b0); chk("rst_if_pc", if_pc, 32'h0); chk("rst_if_inst", if_inst, 32'h0);
        to_pos();

        // 1: streaming fetch, first head two cycles after first grant
        rst = 1'b0; imem_gnt = 1'b1; rsp_en = 1'b1;
        to_neg(); chk1("t1_c0_req", imem_req, 1'b1); chk("t1_c0_addr", imem_addr, 32'h0); chk("t1_c0_inst", if_inst, 32'h0); to_pos();
        to_neg(); chk("t1_c1_addr", imem_addr, 32'h4); chk("t1_c1_inst", if_inst, 32'h0); to_pos();
        to_neg(); chk("t1_c2_pc", if_pc, 32'h0); chk("t1_c2_inst", if_inst, 32'hA5A5_0000); to_pos();
        to_neg(); chk("t1_c3_pc", if_pc, 32'h4); chk("t1_c3_inst", if_inst, 32'hA5A5_0004); to_pos();
        cyc(12);

        // 2: IF/ID hold fills capacity, then releases in order
        do_reset(); rst = 1'b0; imem_gnt = 1'b1; rsp_en = 1'b1; stall = 6'b000010;
        cyc(4);
        to_neg(); chk1("t2_req_off", imem_req, 1'b0); chk("t2_hold_pc", if_pc, 32'h0); chk("t2_hold_inst", if_inst, 32'hA5A5_0000); to_pos();
        stall = 6'b0;
        to_neg(); chk("t2_c5_pc", if_pc, 32'h0); to_pos();
        to_neg(); chk("t2_c6_pc", if_pc, 32'h4); chk("t2_c6_inst", if_inst, 32'hA5A5_0004);
        chk1("t2_c6_req", imem_req, 1'b1); chk("t2_c6_addr", imem_addr, 32'h8); to_pos();
        cyc(10);

        // 3: EX redirect with one queued entry and one request in flight
        do_reset(); rst = 1'b0; imem_gnt = 1'b1; rsp_en = 1'b1; stall = 6'b000010;
        to_neg(); to_pos();
        to_neg(); rsp_en = 1'b0; to_pos();
        ex_b_flag = 1'b1; ex_b_addr = 32'h0000_0103;
        to_neg(); chk("t3_pre_pc", if_pc, 32'h0); chk1("t3_redir_req", imem_req, 1'b0); rsp_en = 1'b1; to_pos();
        ex_b_flag = 1'b0; stall = 6'b0;
        to_neg(); chk1("t3_req", imem_req, 1'b1); chk("t3_addr", imem_addr, 32'h100); chk("t3_flushed", if_inst, 32'h0); to_pos();
        to_neg(); chk("t3_stale_dropped", if_inst, 32'h0); to_pos();
        to_neg(); chk("t3_pc", if_pc, 32'h100); chk("t3_inst", if_inst, 32'hA5A5_0100); to_pos();
        cyc(3);

        // 4: simultaneous EX and ID redirect, EX wins
        ex_b_flag = 1'b1; ex_b_addr = 32'h200; id_b_flag = 1'b1; id_b_addr = 32'h300;
        to_neg(); chk1("t4_req_off", imem_req, 1'b0); to_pos();
        ex_b_flag = 1'b0; id_b_flag = 1'b0;
        to_neg(); chk("t4_addr", imem_addr, 32'h200); to_pos();
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            to_neg();
            if (if_inst != 32'h0) begin
                got = 1'b1;
                chk("t4_pc", if_pc, 32'h200); chk("t4_inst", if_inst, 32'hA5A5_0200);
            end
            to_pos();
        end
        chk1("t4_head_seen", got, 1'b1);

        // 5: grant withheld, then fetch stall; responses still accepted under stall
        do_reset(); rst = 1'b0; imem_gnt = 1'b0; rsp_en = 1'b1;
        cyc(2);
        to_neg(); chk1("t5_wait_req", imem_req, 1'b1); chk("t5_wait_addr", imem_addr, 32'h0); chk("t5_wait_inst", if_inst, 32'h0); to_pos();
        stall = 6'b000001;
        to_neg(); chk1("t5_stall_req", imem_req, 1'b0); chk("t5_stall_addr", imem_addr, 32'h0); chk("t5_stall_inst", if_inst, 32'h0); to_pos();
        stall = 6'b0; imem_gnt = 1'b1;
        to_neg(); chk1("t5_go_req", imem_req, 1'b1); chk("t5_go_addr", imem_addr, 32'h0); to_pos();
        stall = 6'b000001;
        to_neg(); chk1("t5_s0_req", imem_req, 1'b0); to_pos();
        to_neg(); chk("t5_s0_pc", if_pc, 32'h0); chk("t5_s0_inst", if_inst, 32'hA5A5_0000); to_pos();
        stall = 6'b0;
        cyc(6);

        // 6: address wrap, then reset with two requests in flight
        do_reset(); rst = 1'b0; imem_gnt = 1'b1; rsp_en = 1'b0; id_b_flag = 1'b1; id_b_addr = 32'hFFFF_FFFE;
        to_neg(); chk1("t6_redir_req", imem_req, 1'b0); to_pos();
        id_b_flag = 1'b0;
        to_neg(); chk1("t6_top_req", imem_req, 1'b1); chk("t6_top_addr", imem_addr, 32'hFFFF_FFFC); to_pos();
        to_neg(); chk1("t6_wrap_req", imem_req, 1'b1); chk("t6_wrap_addr", imem_addr, 32'h0); to_pos();
        rst = 1'b1;
        to_neg(); chk1("t6_rst_req", imem_req, 1'b0); rsp_en = 1'b1; to_pos();
        rst = 1'b0; stall = 6'b000001; rsp_en = 1'b0; mem_q.delete();
        to_neg(); chk("t6_post_pc", if_pc, 32'h0); chk("t6_post_inst", if_inst, 32'h0); chk("t6_post_addr", imem_addr, RESET_PC); to_pos();
        stall = 6'b0;
        to_neg(); chk1("t6_restart_req", imem_req, 1'b1); chk("t6_restart_addr", imem_addr, RESET_PC); chk("t6_late_ignored", if_inst, 32'h0);
        rsp_en = 1'b1; to_pos();
        to_neg(); chk("t6_c6_inst", if_inst, 32'h0); to_pos();
        to_neg(); chk("t6_head_pc", if_pc, 32'h0); chk("t6_head_inst", if_inst, 32'hA5A5_0000); to_pos();
        cyc(4);

        // Mixed traffic: patterned grants, responses, stalls and redirects, model-checked
        do_reset(); rst = 1'b0;
        pg  = 16'b1101_1011_0111_1110;
        pr  = 16'b1011_0110_1101_1011;
        ps1 = 16'b0001_1000_0000_0110;
        ps0 = 16'b0100_0000_0010_0000;
        for (int i = 0; i < 64; i++) begin
            imem_gnt  = pg[i % 16];
            rsp_en    = pr[(i + 3) % 16];
            stall     = {4'(i), ps1[i % 16], ps0[i % 16]};
            id_b_flag = (i % 23 == 7);
            id_b_addr = 32'h1000 + 32'(i * 8 + 2);
            ex_b_flag = (i % 19 == 11) || (i == 31);
            ex_b_addr = 32'h2000 + 32'(i * 4 + 1);
            cyc(1);
        end
        ex_b_flag = 1'b0; id_b_flag = 1'b0; stall = 6'b0; imem_gnt = 1'b1; rsp_en = 1'b1;
        cyc(10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
